// File: rtl/hazard3_break_sequencer_pkg.sv
// Shared encodings for the debug-entry sequencer: dcsr.cause values and FSM states.
package hazard3_break_sequencer_pkg;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STEP   = 3'd1,
    ST_DREQ   = 3'd2,
    ST_HALTED = 3'd3,
    ST_RESUME = 3'd4
  } state_t;

endpackage

// File: rtl/hazard3_break_sequencer_cause_pri.sv
// Priority encoder from pre-gated break events to one request; M-break is lowest
// and reported via is_mbreak rather than a dcsr cause.
module hazard3_dbg_cause_pri
  import hazard3_break_sequencer_pkg::*;
(
  input  logic       ev_trig_d,
  input  logic       ev_ebreak,
  input  logic       ev_halt,
  input  logic       ev_step,
  input  logic       ev_trig_m,
  output logic       valid,
  output logic [2:0] cause,
  output logic       is_mbreak
);

  always_comb begin
    valid     = 1'b1;
    cause     = CAUSE_NONE;
    is_mbreak = 1'b0;
    if (ev_trig_d)      cause = CAUSE_TRIGGER;
    else if (ev_ebreak) cause = CAUSE_EBREAK;
    else if (ev_halt)   cause = CAUSE_HALTREQ;
    else if (ev_step)   cause = CAUSE_STEP;
    else if (ev_trig_m) is_mbreak = 1'b1;
    else                valid = 1'b0;
  end

endmodule

// File: rtl/hazard3_break_sequencer.sv
// Debug-entry / breakpoint sequencer: arbitrates trigger, ebreak, haltreq and step
// into one held D-mode or M-mode break request and owns the d_mode flag.
module hazard3_break_sequencer
  import hazard3_break_sequencer_pkg::*;
#(
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_break_any,
  input  logic              trig_break_d_mode,
  input  logic              x_valid,
  input  logic              x_stall,
  input  logic [W_ADDR-1:0] x_pc,
  input  logic              x_is_ebreak,
  input  logic              x_retire,
  input  logic              m_mode,
  input  logic              dcsr_ebreakm,
  input  logic              dcsr_ebreaku,
  input  logic              dcsr_step,
  input  logic              haltreq,
  input  logic              resumereq,
  output logic              dbg_req,
  output logic [2:0]        dbg_cause,
  output logic [W_ADDR-1:0] dbg_dpc,
  input  logic              dbg_ack,
  output logic              mbrk_req,
  input  logic              mbrk_ack,
  output logic              d_mode,
  output logic              halted,
  output logic              running,
  output logic              resumeack
);

  state_t            state;
  logic [W_ADDR-1:0] last_pc;
  logic              step_pend;

  logic active, samp, ev_trig_d, ev_ebreak, ev_halt, ev_step, ev_trig_m;
  logic pri_valid, pri_mbreak;
  logic [2:0] pri_cause;

  assign active = (state == ST_RUN) || (state == ST_STEP);
  assign samp   = active && x_valid && !x_stall;

  // A pending M-break blocks every new sample except a trigger D-break, which preempts it.
  assign ev_trig_d = samp && trig_break_any && trig_break_d_mode;
  assign ev_ebreak = samp && !mbrk_req && x_is_ebreak && (m_mode ? dcsr_ebreakm : dcsr_ebreaku);
  assign ev_halt   = !mbrk_req && haltreq && (samp || (state == ST_RUN && !x_valid));
  assign ev_step   = samp && !mbrk_req && step_pend;
  assign ev_trig_m = samp && !mbrk_req && trig_break_any && !trig_break_d_mode;

  hazard3_dbg_cause_pri u_pri (
    .ev_trig_d (ev_trig_d),
    .ev_ebreak (ev_ebreak),
    .ev_halt   (ev_halt),
    .ev_step   (ev_step),
    .ev_trig_m (ev_trig_m),
    .valid     (pri_valid),
    .cause     (pri_cause),
    .is_mbreak (pri_mbreak)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      last_pc   <= '0;
      step_pend <= 1'b0;
      dbg_req   <= 1'b0;
      dbg_cause <= CAUSE_NONE;
      dbg_dpc   <= '0;
      mbrk_req  <= 1'b0;
      d_mode    <= 1'b0;
      halted    <= 1'b0;
      running   <= 1'b1;
      resumeack <= 1'b0;
    end else begin
      resumeack <= 1'b0;
      if (mbrk_ack) mbrk_req <= 1'b0;
      if (samp) last_pc <= x_pc;
      case (state)
        ST_RUN, ST_STEP: begin
          if (pri_valid && pri_mbreak) begin
            mbrk_req <= 1'b1;
          end else if (pri_valid) begin
            mbrk_req  <= 1'b0;
            dbg_req   <= 1'b1;
            dbg_cause <= pri_cause;
            dbg_dpc   <= x_valid ? x_pc : last_pc;
            step_pend <= 1'b0;
            state     <= ST_DREQ;
          end else if (state == ST_STEP && x_retire && !mbrk_req) begin
            // dpc is the next instruction's PC, so entry waits for its X cycle
            step_pend <= 1'b1;
          end
        end
        ST_DREQ: begin
          if (dbg_ack) begin
            dbg_req <= 1'b0;
            d_mode  <= 1'b1;
            halted  <= 1'b1;
            running <= 1'b0;
            state   <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (resumereq) state <= ST_RESUME;
        end
        ST_RESUME: begin
          resumeack <= 1'b1;
          d_mode    <= 1'b0;
          halted    <= 1'b0;
          running   <= 1'b1;
          state     <= dcsr_step ? ST_STEP : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_break_sequencer.sv
// Self-checking bench: expected D-entry {cause,dpc} pushed at stimulus time and
// popped when dbg_req rises; handshake and status outputs checked directly.
module tb_hazard3_break_sequencer;

  localparam int W_ADDR = 32;

  logic clk = 1'b0;
  logic rst;
  logic trig_break_any, trig_break_d_mode, x_valid, x_stall, x_is_ebreak, x_retire;
  logic m_mode, dcsr_ebreakm, dcsr_ebreaku, dcsr_step, haltreq, resumereq;
  logic [W_ADDR-1:0] x_pc;
  logic dbg_req, dbg_ack, mbrk_req, mbrk_ack, d_mode, halted, running, resumeack;
  logic [2:0] dbg_cause;
  logic [W_ADDR-1:0] dbg_dpc;

  typedef struct packed {
    logic [2:0]        cause;
    logic [W_ADDR-1:0] dpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  hazard3_break_sequencer #(.W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst),
    .trig_break_any(trig_break_any), .trig_break_d_mode(trig_break_d_mode),
    .x_valid(x_valid), .x_stall(x_stall), .x_pc(x_pc),
    .x_is_ebreak(x_is_ebreak), .x_retire(x_retire), .m_mode(m_mode),
    .dcsr_ebreakm(dcsr_ebreakm), .dcsr_ebreaku(dcsr_ebreaku), .dcsr_step(dcsr_step),
    .haltreq(haltreq), .resumereq(resumereq),
    .dbg_req(dbg_req), .dbg_cause(dbg_cause), .dbg_dpc(dbg_dpc), .dbg_ack(dbg_ack),
    .mbrk_req(mbrk_req), .mbrk_ack(mbrk_ack),
    .d_mode(d_mode), .halted(halted), .running(running), .resumeack(resumeack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    trig_break_any = 0; trig_break_d_mode = 0; x_valid = 0; x_stall = 0;
    x_is_ebreak = 0; x_retire = 0; x_pc = '0; haltreq = 0; resumereq = 0;
    dbg_ack = 0; mbrk_ack = 0;
  endtask

  task automatic ack();
    dbg_ack = 1; tick(); dbg_ack = 0;
    chk("ack_req_low", dbg_req, 0);
    chk("ack_dmode", d_mode, 1);
    chk("ack_halted", halted, 1);
  endtask

  task automatic resume(input logic step);
    dcsr_step = step;
    resumereq = 1; tick(); resumereq = 0;
    chk("res_n1_ack", resumeack, 0);
    tick();
    chk("res_n2_ack", resumeack, 1);
    chk("res_n2_dmode", d_mode, 0);
    chk("res_n2_running", running, 1);
    tick();
    chk("res_n3_ack", resumeack, 0);
  endtask

  // Scoreboard pop on each dbg_req rising edge
  always @(posedge clk) begin
    #2;
    if (dbg_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_req", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_cause", {29'd0, dbg_cause}, {29'd0, e.cause});
        chk("sb_dpc", dbg_dpc, e.dpc);
      end
    end
    req_prev = dbg_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_mode = 0; dcsr_ebreakm = 0; dcsr_ebreaku = 0; dcsr_step = 0;
    rst = 1; tick(); tick();
    chk("rst_dbg_req", dbg_req, 0);
    chk("rst_mbrk_req", mbrk_req, 0);
    chk("rst_dmode", d_mode, 0);
    chk("rst_running", running, 1);
    chk("rst_halted", halted, 0);
    chk("rst_resumeack", resumeack, 0);
    chk("rst_cause", {29'd0, dbg_cause}, 0);
    chk("rst_dpc", dbg_dpc, 0);
    rst = 0; tick();

    // trigger D-break
    x_valid = 1; x_pc = 32'h400; trig_break_any = 1; trig_break_d_mode = 1;
    exp_q.push_back('{3'd2, 32'h400});
    tick(); idle();
    chk("trig_req", dbg_req, 1);
    tick();
    chk("trig_req_held", dbg_req, 1);
    ack();
    resume(0);

    // ebreak beats simultaneous trigger M-break
    x_valid = 1; x_pc = 32'h200; trig_break_any = 1; x_is_ebreak = 1;
    m_mode = 1; dcsr_ebreakm = 1;
    exp_q.push_back('{3'd1, 32'h200});
    tick(); idle();
    chk("pri_req", dbg_req, 1);
    chk("pri_mbrk", mbrk_req, 0);
    ack();
    resume(0);

    // ebreak without enable is ignored
    dcsr_ebreakm = 0;
    x_valid = 1; x_pc = 32'h220; x_is_ebreak = 1;
    tick(); idle();
    chk("ebrk_off_req", dbg_req, 0);
    chk("ebrk_off_mbrk", mbrk_req, 0);

    // M-break handshake, ack held off 3 cycles
    x_valid = 1; x_pc = 32'h300; trig_break_any = 1;
    tick(); idle();
    chk("mbrk_rise", mbrk_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mbrk_held", mbrk_req, 1);
      chk("mbrk_dmode", d_mode, 0);
    end
    mbrk_ack = 1; tick(); mbrk_ack = 0;
    chk("mbrk_acked", mbrk_req, 0);

    // D-break preempts pending M-break
    x_valid = 1; x_pc = 32'h310; trig_break_any = 1;
    tick(); idle();
    chk("mbrk2_rise", mbrk_req, 1);
    x_valid = 1; x_pc = 32'h320; trig_break_any = 1; trig_break_d_mode = 1;
    exp_q.push_back('{3'd2, 32'h320});
    tick(); idle();
    chk("preempt_mbrk", mbrk_req, 0);
    chk("preempt_req", dbg_req, 1);
    ack();
    resume(0);

    // idle haltreq uses last sampled PC
    haltreq = 1;
    exp_q.push_back('{3'd3, 32'h320});
    tick(); haltreq = 0;
    chk("halt_idle_req", dbg_req, 1);
    ack();
    resume(1);

    // single step
    x_valid = 1; x_pc = 32'h100; x_retire = 1;
    tick(); x_retire = 0;
    chk("step_retire_noreq", dbg_req, 0);
    x_pc = 32'h104;
    exp_q.push_back('{3'd4, 32'h104});
    tick(); idle();
    chk("step_req", dbg_req, 1);
    ack();
    resume(0);

    // haltreq blocked by stall
    x_valid = 1; x_stall = 1; x_pc = 32'h500; haltreq = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_noreq", dbg_req, 0);
    end
    x_stall = 0;
    exp_q.push_back('{3'd3, 32'h500});
    tick(); idle();
    chk("stall_release_req", dbg_req, 1);

    // reset during DREQ
    rst = 1; tick(); rst = 0;
    chk("rst_dreq_req", dbg_req, 0);
    chk("rst_dreq_dmode", d_mode, 0);
    chk("rst_dreq_running", running, 1);

    // reset during HALTED; last_pc is back to 0
    haltreq = 1;
    exp_q.push_back('{3'd3, 32'h0});
    tick(); haltreq = 0;
    ack();
    rst = 1; tick(); rst = 0;
    chk("rst_halt_halted", halted, 0);
    chk("rst_halt_running", running, 1);
    chk("rst_halt_dmode", d_mode, 0);
    chk("rst_halt_resumeack", resumeack, 0);

    // haltreq and resumereq together in HALTED: resume, then halt again
    haltreq = 1;
    exp_q.push_back('{3'd3, 32'h0});
    tick();
    ack();
    dcsr_step = 0;
    resumereq = 1;
    exp_q.push_back('{3'd3, 32'h0});
    tick(); resumereq = 0;
    chk("both_n1_halted", halted, 1);
    tick();
    chk("both_n2_ack", resumeack, 1);
    chk("both_n2_dmode", d_mode, 0);
    tick(); haltreq = 0;
    chk("both_rehalt_req", dbg_req, 1);
    chk("both_n3_ack", resumeack, 0);
    ack();
    tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
